tick_scheduler: RTL and testbench

TICK_SCHEDULER -- requirements
Module: tick_scheduler

---
 rtl/tick_scheduler.sv | 135 +++++++++++++
 tb/tb_tick_scheduler.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/tick_scheduler.sv
// Tick scheduler: a run/pause/step controller that divides the system clock into
// count-enable pulses for a downstream counter, with a selectable tick rate.
module tick_scheduler #(
  parameter int unsigned DIV0 = 32'd50000000,
  parameter int unsigned DIV1 = 32'd25000000,
  parameter int unsigned DIV2 = 32'd10000000,
  parameter int unsigned DIV3 = 32'd5000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        stop,
  input  logic        step,
  input  logic        clear,
  input  logic [1:0]  rate_sel,
  output logic        cnt_en,
  output logic        cnt_clr,
  output logic        running,
  output logic        paused,
  output logic [15:0] tick_count
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2
  } state_t;

  // A divider of zero would never wrap, so it is treated as one.
  function automatic logic [31:0] sel_div(input logic [1:0] sel);
    logic [31:0] raw;
    case (sel)
      2'd0:    raw = 32'(DIV0);
      2'd1:    raw = 32'(DIV1);
      2'd2:    raw = 32'(DIV2);
      2'd3:    raw = 32'(DIV3);
      default: raw = 32'(DIV0);
    endcase
    sel_div = (raw == 32'd0) ? 32'd1 : raw;
  endfunction

  state_t      state_q, state_d;
  logic [31:0] presc_q, presc_d;
  logic [31:0] div_q, div_d;
  logic [15:0] tick_q, tick_d;
  logic        cnt_en_q, cnt_en_d;
  logic        cnt_clr_q, cnt_clr_d;
  logic        running_q, running_d;
  logic        paused_q, paused_d;
  logic        wrap_s;

  assign wrap_s = (state_q == ST_RUN) && (presc_q == (div_q - 32'd1));

  // Next-state: commands resolved by priority clear > stop > start > step.
  always_comb begin
    state_d   = state_q;
    presc_d   = presc_q;
    div_d     = div_q;
    tick_d    = tick_q;
    cnt_en_d  = 1'b0;
    cnt_clr_d = 1'b0;

    if (clear) begin
      state_d   = ST_IDLE;
      presc_d   = 32'd0;
      tick_d    = 16'd0;
      cnt_clr_d = 1'b1;
    end else if (stop) begin
      if (state_q == ST_RUN) begin
        state_d = ST_PAUSE;
      end else begin
        state_d = state_q;
      end
    end else if (start && (state_q != ST_RUN)) begin
      state_d = ST_RUN;
      div_d   = sel_div(rate_sel);
      if (state_q == ST_IDLE) begin
        presc_d = 32'd0;
      end else begin
        presc_d = presc_q;
      end
    end else if (state_q == ST_RUN) begin
      if (wrap_s) begin
        presc_d  = 32'd0;
        div_d    = sel_div(rate_sel);
        cnt_en_d = 1'b1;
      end else begin
        presc_d = presc_q + 32'd1;
      end
    end else if (step) begin
      cnt_en_d = 1'b1;
    end else begin
      cnt_en_d = 1'b0;
    end

    if (cnt_en_d) begin
      tick_d = tick_q + 16'd1;
    end else begin
      tick_d = tick_d;
    end

    running_d = (state_d == ST_RUN);
    paused_d  = (state_d == ST_PAUSE);
  end

  // State and registered outputs, cleared asynchronously by reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      presc_q   <= 32'd0;
      div_q     <= sel_div(2'd0);
      tick_q    <= 16'd0;
      cnt_en_q  <= 1'b0;
      cnt_clr_q <= 1'b0;
      running_q <= 1'b0;
      paused_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      presc_q   <= presc_d;
      div_q     <= div_d;
      tick_q    <= tick_d;
      cnt_en_q  <= cnt_en_d;
      cnt_clr_q <= cnt_clr_d;
      running_q <= running_d;
      paused_q  <= paused_d;
    end
  end

  assign cnt_en     = cnt_en_q;
  assign cnt_clr    = cnt_clr_q;
  assign running    = running_q;
  assign paused     = paused_q;
  assign tick_count = tick_q;

endmodule

// File: tb/tb_tick_scheduler.sv
// Directed bench for tick_scheduler: expected ticks (edge number and count) are
// queued as stimulus is driven and compared whenever cnt_en is observed.
module tb_tick_scheduler;

  logic        clk;
  logic        rst;
  logic        start;
  logic        stop;
  logic        step;
  logic        clear;
  logic [1:0]  rate_sel;
  logic        cnt_en;
  logic        cnt_clr;
  logic        running;
  logic        paused;
  logic [15:0] tick_count;

  typedef struct {
    int          edge_n;
    logic [15:0] cnt;
  } exp_t;

  exp_t exp_q[$];
  int   edge_cnt = 0;
  int   n_tests  = 0;
  int   n_fail   = 0;

  tick_scheduler #(.DIV0(4), .DIV1(3), .DIV2(2), .DIV3(0)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .stop       (stop),
    .step       (step),
    .clear      (clear),
    .rate_sel   (rate_sel),
    .cnt_en     (cnt_en),
    .cnt_clr    (cnt_clr),
    .running    (running),
    .paused     (paused),
    .tick_count (tick_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push(input int e, input logic [15:0] c);
    exp_t x;
    x.edge_n = e;
    x.cnt    = c;
    exp_q.push_back(x);
  endtask

  // Scoreboard: every observed cnt_en must match the oldest queued expectation.
  always @(negedge clk) begin
    if (rst && cnt_en) begin
      check("tick_pending", 32'(exp_q.size() > 0), 32'd1);
      if (exp_q.size() > 0) begin
        exp_t x;
        x = exp_q.pop_front();
        check("tick_edge", 32'(edge_cnt), 32'(x.edge_n));
        check("tick_count_at_tick", 32'(tick_count), 32'(x.cnt));
      end
    end
  end

  initial begin
    int e0;
    int t;
    int k;
    rst = 1'b1; start = 1'b0; stop = 1'b0; step = 1'b0; clear = 1'b0; rate_sel = 2'd0;

    // Reset state, with a start held during reset that must be ignored.
    #1 rst = 1'b0;
    #1;
    check("rst_cnt_en", 32'(cnt_en), 32'd0);
    check("rst_cnt_clr", 32'(cnt_clr), 32'd0);
    check("rst_running", 32'(running), 32'd0);
    check("rst_paused", 32'(paused), 32'd0);
    check("rst_tick_count", 32'(tick_count), 32'd0);
    start = 1'b1;
    cyc(3);
    start = 1'b0;
    rst   = 1'b1;
    cyc(2);
    check("cmd_ignored_in_rst", 32'(running), 32'd0);

    // Rate 0 run: ticks after E0+4, +8, +12.
    e0 = edge_cnt + 1;
    push(e0 + 4, 16'd1);
    push(e0 + 8, 16'd2);
    push(e0 + 12, 16'd3);
    start = 1'b1; cyc(1); start = 1'b0;
    check("run_running", 32'(running), 32'd1);
    check("run_paused", 32'(paused), 32'd0);
    cyc(14);
    check("run_tick_count3", 32'(tick_count), 32'd3);

    // Pause two cycles after a tick, hold, resume: tick two edges after resume.
    stop = 1'b1; cyc(1); stop = 1'b0;
    check("pause_paused", 32'(paused), 32'd1);
    check("pause_running", 32'(running), 32'd0);
    cyc(10);
    check("pause_tick_count", 32'(tick_count), 32'd3);
    t = edge_cnt + 1 + 2;
    push(t, 16'd4);
    start = 1'b1; cyc(1); start = 1'b0;
    check("resume_running", 32'(running), 32'd1);
    cyc(2);

    // Rate change one cycle after a tick only applies after the current period.
    cyc(1);
    rate_sel = 2'd1;
    push(t + 4, 16'd5);
    push(t + 7, 16'd6);
    push(t + 10, 16'd7);
    cyc(11);

    // All commands together on a wrap edge: clear wins, no tick from the wrap.
    stop = 1'b1; clear = 1'b1; start = 1'b1; step = 1'b1;
    cyc(1);
    stop = 1'b0; clear = 1'b0; start = 1'b0; step = 1'b0;
    check("clr_cnt_clr", 32'(cnt_clr), 32'd1);
    check("clr_tick_count", 32'(tick_count), 32'd0);
    check("clr_cnt_en", 32'(cnt_en), 32'd0);
    check("clr_running", 32'(running), 32'd0);
    check("clr_paused", 32'(paused), 32'd0);
    cyc(1);
    check("clr_one_cycle", 32'(cnt_clr), 32'd0);
    cyc(2);

    // Manual steps in IDLE, then a step in RUN that must not add a pulse.
    for (int i = 1; i <= 3; i++) begin
      push(edge_cnt + 1, 16'(i));
      step = 1'b1; cyc(1); step = 1'b0;
      check("step_cnt_en", 32'(cnt_en), 32'd1);
      cyc(2);
    end
    check("step_tick_count", 32'(tick_count), 32'd3);
    check("step_running", 32'(running), 32'd0);
    rate_sel = 2'd0;
    e0 = edge_cnt + 1;
    push(e0 + 4, 16'd4);
    start = 1'b1; cyc(1); start = 1'b0;
    cyc(1);
    step = 1'b1; cyc(1); step = 1'b0;
    cyc(2);
    check("step_in_run_count", 32'(tick_count), 32'd4);
    clear = 1'b1; cyc(1); clear = 1'b0;
    check("clr2_tick_count", 32'(tick_count), 32'd0);
    cyc(1);

    // Preload to 0xFFFF with continuous steps, then DIV3=0 runs every cycle and wraps.
    rate_sel = 2'd3;
    k = edge_cnt;
    for (int i = 1; i <= 65535; i++) push(k + i, 16'(i));
    step = 1'b1; cyc(65535); step = 1'b0;
    check("preload_tick_count", 32'(tick_count), 32'hFFFF);
    cyc(1);
    e0 = edge_cnt + 1;
    push(e0 + 1, 16'h0000);
    push(e0 + 2, 16'h0001);
    push(e0 + 3, 16'h0002);
    start = 1'b1; cyc(1); start = 1'b0;
    cyc(4);
    check("fast_cnt_en", 32'(cnt_en), 32'd1);
    check("fast_tick_count", 32'(tick_count), 32'd3);

    // Asynchronous reset mid-cycle clears everything at once; stays IDLE afterwards.
    #2 rst = 1'b0;
    #1;
    check("arst_cnt_en", 32'(cnt_en), 32'd0);
    check("arst_tick_count", 32'(tick_count), 32'd0);
    check("arst_running", 32'(running), 32'd0);
    check("arst_paused", 32'(paused), 32'd0);
    check("arst_cnt_clr", 32'(cnt_clr), 32'd0);
    cyc(2);
    rst = 1'b1;
    cyc(6);
    check("post_rst_idle", 32'(running), 32'd0);
    check("post_rst_count", 32'(tick_count), 32'd0);
    check("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
